karatsuba_mult_pipe: RTL and testbench

//  - Parametrised, pipelined one-level Karatsuba multiplier; successor to the fixed 65x65 unsigned multiplier.
//  - Adds configurable width/split, per-operation signed/unsigned mode, a valid/ready handshake with backpressure, and a tag passthrough.
//  - Sits in the datapath as a drop-in wide multiplier between operand-staging logic and the accumulator/reduction stage.

---
 rtl/karatsuba_pkg.sv | 19 +
 rtl/kmul_base.sv | 39 +++
 rtl/karatsuba_mult_pipe.sv | 148 ++++++++++++++
 tb/tb_karatsuba_mult_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared helpers and default configuration for the pipelined Karatsuba multiplier.
// Per-instance widths are derived inside each module from its own parameters.
package karatsuba_pkg;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int DEF_WIDTH   = 65;
   localparam int DEF_LO_W    = 32;
   localparam int DEF_MUL_LAT = 1;
   localparam int DEF_TAG_W   = 4;

   localparam int DEF_HI_W    = DEF_WIDTH - DEF_LO_W;
   localparam int DEF_SUM_W   = max_i(DEF_LO_W, DEF_HI_W) + 1;
   localparam int DEF_PROD_W  = 2 * DEF_SUM_W;
   localparam int DEF_LAT     = DEF_MUL_LAT + 2;

endpackage

// File: rtl/kmul_base.sv
// Unsigned AW x BW base multiplier with LAT register stages sharing one enable.
// The product is formed ahead of the first register; later stages only retime it.
module kmul_base
   import karatsuba_pkg::*;
#(
   parameter int AW  = 8,
   parameter int BW  = 8,
   parameter int LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [AW-1:0]     a,
   input  logic [BW-1:0]     b,
   output logic [AW+BW-1:0]  p
);
   localparam int PW = AW + BW;

   logic [PW-1:0] p_d [LAT];
   logic [PW-1:0] p_q [LAT];

   always_comb begin
      p_d[0] = PW'(a) * PW'(b);
      for (int i = 1; i < LAT; i++) begin
         p_d[i] = p_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) p_q[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < LAT; i++) p_q[i] <= p_d[i];
      end
   end

   assign p = p_q[LAT-1];

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// Pipelined one-level Karatsuba multiplier: sign-magnitude front end, three base
// products, recombine/negate register, and a single global stall enable.
module karatsuba_mult_pipe
   import karatsuba_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LO_W    = DEF_LO_W,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_result,
   output logic [TAG_W-1:0]     out_tag
);
   localparam int HI_W   = WIDTH - LO_W;
   localparam int SUM_W  = max_i(LO_W, HI_W) + 1;
   localparam int PROD_W = 2 * SUM_W;
   localparam int RES_W  = 2 * WIDTH;

   // Handshake: an op moves on in_valid & in_ready, a result leaves on
   // out_valid & out_ready; a held result freezes every stage at once.
   logic stall, en;
   logic a_neg, b_neg;

   logic              s0_valid_d, s0_valid_q;
   logic              s0_neg_d, s0_neg_q;
   logic [TAG_W-1:0]  s0_tag_d, s0_tag_q;
   logic [WIDTH-1:0]  s0_a_d, s0_a_q, s0_b_d, s0_b_q;

   logic [LO_W-1:0]   a0, b0;
   logic [HI_W-1:0]   a1, b1;
   logic [SUM_W-1:0]  a_sum, b_sum;
   logic [2*LO_W-1:0] p0;
   logic [2*HI_W-1:0] p1;
   logic [PROD_W-1:0] ps;

   logic              sb_valid_d [MUL_LAT];
   logic              sb_valid_q [MUL_LAT];
   logic              sb_neg_d   [MUL_LAT];
   logic              sb_neg_q   [MUL_LAT];
   logic [TAG_W-1:0]  sb_tag_d   [MUL_LAT];
   logic [TAG_W-1:0]  sb_tag_q   [MUL_LAT];

   logic [PROD_W-1:0] mid;
   logic [RES_W-1:0]  mag;
   logic              out_valid_d, out_valid_q;
   logic [RES_W-1:0]  out_result_d, out_result_q;
   logic [TAG_W-1:0]  out_tag_d, out_tag_q;

   always_comb begin
      stall    = out_valid_q & ~out_ready;
      en       = ~stall;
      in_ready = ~reset & ~stall;
   end

   // Magnitudes stay WIDTH bits: the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      a_neg      = in_signed & in_a[WIDTH-1];
      b_neg      = in_signed & in_b[WIDTH-1];
      s0_a_d     = a_neg ? -in_a : in_a;
      s0_b_d     = b_neg ? -in_b : in_b;
      s0_neg_d   = a_neg ^ b_neg;
      s0_tag_d   = in_tag;
      s0_valid_d = in_valid;
   end

   always_comb begin
      a0    = s0_a_q[LO_W-1:0];
      a1    = s0_a_q[WIDTH-1:LO_W];
      b0    = s0_b_q[LO_W-1:0];
      b1    = s0_b_q[WIDTH-1:LO_W];
      a_sum = SUM_W'(a0) + SUM_W'(a1);
      b_sum = SUM_W'(b0) + SUM_W'(b1);
   end

   kmul_base #(.AW(LO_W),  .BW(LO_W),  .LAT(MUL_LAT)) u_p0 (
      .clk(clk), .reset(reset), .en(en), .a(a0),    .b(b0),    .p(p0));
   kmul_base #(.AW(HI_W),  .BW(HI_W),  .LAT(MUL_LAT)) u_p1 (
      .clk(clk), .reset(reset), .en(en), .a(a1),    .b(b1),    .p(p1));
   kmul_base #(.AW(SUM_W), .BW(SUM_W), .LAT(MUL_LAT)) u_ps (
      .clk(clk), .reset(reset), .en(en), .a(a_sum), .b(b_sum), .p(ps));

   always_comb begin
      sb_valid_d[0] = s0_valid_q;
      sb_neg_d[0]   = s0_neg_q;
      sb_tag_d[0]   = s0_tag_q;
      for (int i = 1; i < MUL_LAT; i++) begin
         sb_valid_d[i] = sb_valid_q[i-1];
         sb_neg_d[i]   = sb_neg_q[i-1];
         sb_tag_d[i]   = sb_tag_q[i-1];
      end
   end

   // Every partial term is non-negative, so the truncated sum is exact.
   always_comb begin
      mid          = ps - PROD_W'(p0) - PROD_W'(p1);
      mag          = (RES_W'(p1) << (2 * LO_W)) + (RES_W'(mid) << LO_W) + RES_W'(p0);
      out_result_d = sb_neg_q[MUL_LAT-1] ? -mag : mag;
      out_valid_d  = sb_valid_q[MUL_LAT-1];
      out_tag_d    = sb_tag_q[MUL_LAT-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid_q   <= 1'b0;
         s0_neg_q     <= 1'b0;
         s0_tag_q     <= '0;
         s0_a_q       <= '0;
         s0_b_q       <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            sb_valid_q[i] <= 1'b0;
            sb_neg_q[i]   <= 1'b0;
            sb_tag_q[i]   <= '0;
         end
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
      end else if (en) begin
         s0_valid_q   <= s0_valid_d;
         s0_neg_q     <= s0_neg_d;
         s0_tag_q     <= s0_tag_d;
         s0_a_q       <= s0_a_d;
         s0_b_q       <= s0_b_d;
         for (int i = 0; i < MUL_LAT; i++) begin
            sb_valid_q[i] <= sb_valid_d[i];
            sb_neg_q[i]   <= sb_neg_d[i];
            sb_tag_q[i]   <= sb_tag_d[i];
         end
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Directed and random checks of karatsuba_mult_pipe at default and small widths,
// with expected products queued at accept time and matched at the output.
module tb_karatsuba_mult_pipe;
   localparam int W  = 65;
   localparam int TW = 4;
   localparam int SW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic            in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [W-1:0]    in_a, in_b;
   logic [TW-1:0]   in_tag, out_tag;
   logic [2*W-1:0]  out_result;

   logic            s_in_valid, s_in_ready, s_in_signed, s_out_valid, s_out_ready;
   logic [SW-1:0]   s_in_a, s_in_b;
   logic [TW-1:0]   s_in_tag, s_out_tag;
   logic [2*SW-1:0] s_out_result;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int n_out_s  = 0;
   int base;

   logic [TW+2*W-1:0]  exp_q[$];
   logic [TW+2*SW-1:0] exp_s_q[$];
   logic [TW+2*W-1:0]  mon_e;
   logic [TW+2*SW-1:0] mon_s_e;
   logic [SW-1:0]      corners [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
   logic [95:0]        rnd_a, rnd_b;
   bit                 rnd_s;

   karatsuba_mult_pipe dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag));

   karatsuba_mult_pipe #(.WIDTH(SW), .LO_W(5), .MUL_LAT(2), .TAG_W(TW)) dut_s (
      .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_signed(s_in_signed), .in_a(s_in_a), .in_b(s_in_b), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
      .out_tag(s_out_tag));

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, expv);
      end
   endtask

   function automatic logic [2*W-1:0] model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] ea, eb;
      ea = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction

   function automatic logic [2*SW-1:0] model_s(input logic [SW-1:0] a, input logic [SW-1:0] b);
      logic [2*SW-1:0] ea, eb;
      ea = {{SW{a[SW-1]}}, a};
      eb = {{SW{b[SW-1]}}, b};
      return ea * eb;
   endfunction

   // Scoreboards: pop on every consumed result.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         chk("sb_entry_present", (2*W)'(exp_q.size() != 0), (2*W)'(1));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("result", out_result, mon_e[2*W-1:0]);
            chk("tag", (2*W)'(out_tag), (2*W)'(mon_e[TW+2*W-1:2*W]));
         end
         n_out++;
      end
   end

   always @(negedge clk) begin
      if (!reset && s_out_valid && s_out_ready) begin
         chk("s_sb_entry_present", (2*W)'(exp_s_q.size() != 0), (2*W)'(1));
         if (exp_s_q.size() != 0) begin
            mon_s_e = exp_s_q.pop_front();
            chk("s_result", (2*W)'(s_out_result), (2*W)'(mon_s_e[2*SW-1:0]));
            chk("s_tag", (2*W)'(s_out_tag), (2*W)'(mon_s_e[TW+2*SW-1:2*SW]));
         end
         n_out_s++;
      end
   end

   task automatic send(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [2*W-1:0] expv);
      bit ok;
      ok        = 1'b0;
      in_valid  = 1'b1;
      in_signed = sg;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            exp_q.push_back({tag, expv});
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("accept", (2*W)'(ok), (2*W)'(1));
   endtask

   task automatic send_s(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [TW-1:0] tag);
      bit ok;
      ok          = 1'b0;
      s_in_valid  = 1'b1;
      s_in_signed = 1'b1;
      s_in_a      = a;
      s_in_b      = b;
      s_in_tag    = tag;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (s_in_ready) begin
            ok = 1'b1;
            exp_s_q.push_back({tag, model_s(a, b)});
         end
         @(posedge clk);
         #1;
      end
      s_in_valid = 1'b0;
      chk("s_accept", (2*W)'(ok), (2*W)'(1));
   endtask

   task automatic drain(input int bound);
      for (int k = 0; k < bound && exp_q.size() != 0; k++) @(posedge clk);
      #1;
   endtask

   task automatic drain_s(input int bound);
      for (int k = 0; k < bound && exp_s_q.size() != 0; k++) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_signed = 1'b0; s_in_a = '0; s_in_b = '0; s_in_tag = '0; s_out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", (2*W)'(in_ready), '0);
      chk("rst_out_valid", (2*W)'(out_valid), '0);
      chk("rst_out_result", out_result, '0);
      chk("rst_out_tag", (2*W)'(out_tag), '0);
      chk("rst_s_in_ready", (2*W)'(s_in_ready), '0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", (2*W)'(in_ready), (2*W)'(1));
      @(posedge clk); #1;

      // Max unsigned operands and three-cycle latency
      send(1'b0, {W{1'b1}}, {W{1'b1}}, 4'hA, (2*W)'(0) - ((2*W)'(1) << 66) + (2*W)'(1));
      @(negedge clk); chk("lat_cycle1", (2*W)'(out_valid), '0);
      @(negedge clk); chk("lat_cycle2", (2*W)'(out_valid), '0);
      @(negedge clk); chk("lat_cycle3", (2*W)'(out_valid), (2*W)'(1));
      drain(5);

      // Signed corners, unsigned large value, signed zero
      send(1'b1, 65'h1_0000_0000_0000_0000, {W{1'b1}}, 4'h1, (2*W)'(1) << 64);
      send(1'b1, 65'h1_0000_0000_0000_0000, 65'h0_FFFF_FFFF_FFFF_FFFF, 4'h2,
           (2*W)'(0) - ((2*W)'(1) << 128) + ((2*W)'(1) << 64));
      send(1'b0, 65'h1_0000_0000_0000_0000, 65'd3, 4'h3, (2*W)'(3) << 64);
      send(1'b1, 65'd0, 65'd0 - 65'd5, 4'h4, '0);
      drain(6);
      chk("directed_drained", (2*W)'(exp_q.size()), '0);

      // Back-to-back random mixed-mode stream
      base = n_out;
      for (int i = 0; i < 20; i++) begin
         rnd_a = {$urandom(), $urandom(), $urandom()};
         rnd_b = {$urandom(), $urandom(), $urandom()};
         rnd_s = 1'($urandom_range(0, 1));
         send(rnd_s, rnd_a[W-1:0], rnd_b[W-1:0], TW'(i), model(rnd_s, rnd_a[W-1:0], rnd_b[W-1:0]));
      end
      drain(5);
      chk("stream_drained", (2*W)'(exp_q.size()), '0);
      chk("stream_count", (2*W)'(n_out - base), (2*W)'(20));

      // Backpressure hold for five cycles
      base = n_out;
      send(1'b1, 65'd0 - 65'd7, 65'd11, 4'h5, model(1'b1, 65'd0 - 65'd7, 65'd11));
      send(1'b0, 65'h1_2345_6789_ABCD_EF01, 65'h0_FEDC_BA98_7654_3210, 4'h6,
           model(1'b0, 65'h1_2345_6789_ABCD_EF01, 65'h0_FEDC_BA98_7654_3210));
      send(1'b1, 65'd123456789, 65'd0 - 65'd987654321, 4'h7,
           model(1'b1, 65'd123456789, 65'd0 - 65'd987654321));
      out_ready = 1'b0;
      for (int k = 0; k < 10 && !out_valid; k++) @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_in_ready", (2*W)'(in_ready), '0);
         chk("stall_out_valid", (2*W)'(out_valid), (2*W)'(1));
         chk("stall_result_hold", out_result, exp_q[0][2*W-1:0]);
         chk("stall_tag_hold", (2*W)'(out_tag), (2*W)'(exp_q[0][TW+2*W-1:2*W]));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain(20);
      repeat (5) @(posedge clk);
      chk("stall_drained", (2*W)'(exp_q.size()), '0);
      chk("stall_count", (2*W)'(n_out - base), (2*W)'(3));

      // Reset with ops in flight
      send(1'b0, 65'd100, 65'd200, 4'h8, model(1'b0, 65'd100, 65'd200));
      send(1'b0, 65'd300, 65'd400, 4'h9, model(1'b0, 65'd300, 65'd400));
      send(1'b0, 65'd500, 65'd600, 4'hB, model(1'b0, 65'd500, 65'd600));
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_in_ready", (2*W)'(in_ready), '0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_no_output", (2*W)'(out_valid), '0);
      end
      @(posedge clk); #1;
      base = n_out;
      send(1'b1, 65'd0 - 65'd3, 65'd0 - 65'd9, 4'hC, (2*W)'(27));
      drain(6);
      chk("post_rst_drained", (2*W)'(exp_q.size()), '0);
      chk("post_rst_count", (2*W)'(n_out - base), (2*W)'(1));

      // Small configuration: signed corner pairs
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            send_s(corners[i], corners[j], TW'(i * 5 + j));
         end
      end
      drain_s(8);
      chk("s_drained", (2*W)'(exp_s_q.size()), '0);
      chk("s_count", (2*W)'(n_out_s), (2*W)'(25));

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
